// File: rtl/branch_history_table_pkg.sv
// Shared types and constants for the branch history table.
// Holds the 2-bit saturating counter type, its encodings and the step function.
package bht_pkg;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_SNT   = 2'b00;
    localparam bht_cnt_t BHT_WNT   = 2'b01;
    localparam bht_cnt_t BHT_WT    = 2'b10;
    localparam bht_cnt_t BHT_ST    = 2'b11;
    localparam bht_cnt_t BHT_RESET = BHT_WNT;

    // One training step: move towards ST on taken, towards SNT on not-taken,
    // holding at either end.
    function automatic bht_cnt_t bht_step(input bht_cnt_t cnt, input logic inc);
        bht_cnt_t nxt;
        nxt = cnt;
        if (inc) begin
            if (cnt != BHT_ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != BHT_SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_history_table_if.sv
// Fetch/execute-side signal bundle of the branch history table.
// master = core side (drives PCs and resolved outcomes), slave = predictor.
interface branch_history_table_if;

    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_pred;
    logic        mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output pred_pc, upd_valid, upd_pc, upd_taken, upd_pred,
        input  pred_taken, mispredict, stat_branches, stat_mispredicts
    );

    modport slave (
        input  pred_pc, upd_valid, upd_pc, upd_taken, upd_pred,
        output pred_taken, mispredict, stat_branches, stat_mispredicts
    );

endinterface

// File: rtl/branch_history_table_sat_counter2.sv
// One 2-bit saturating direction counter; resets to weakly not-taken.
module sat_counter2
    import bht_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     inc,
    output bht_cnt_t cnt
);

    bht_cnt_t cnt_reg;

    // Counter state: reset wins over a concurrent training step.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= BHT_RESET;
        end else if (en) begin
            cnt_reg <= bht_step(cnt_reg, inc);
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/branch_history_table.sv
// Direct-mapped table of 2-bit saturating counters indexed by PC[IDX_W+1:2].
// Lookup is combinational; training lands on the next clock edge with no
// write-to-read bypass. Optional statistics counters are built only when
// the macro BHT_STATS_EN is defined; otherwise the stat ports read zero.
module branch_history_table
    import bht_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_history_table_if.slave  bus
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    bht_cnt_t         cnt_arr [ENTRIES];
    logic             mispredict_w;

    assign pred_idx = bus.pred_pc[IDX_W+1:2];
    assign upd_idx  = bus.upd_pc[IDX_W+1:2];

    // Byte-offset bits and bits above the index are deliberately ignored
    // (aliasing is allowed); fold them here so they are visibly consumed.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pred_pc[31:IDX_W+2], bus.pred_pc[1:0],
                              bus.upd_pc[31:IDX_W+2],  bus.upd_pc[1:0]};

    // Counter array: only the entry whose index matches the update PC trains.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic entry_en;
        assign entry_en = bus.upd_valid && (upd_idx == IDX_W'(gi));

        sat_counter2 u_cnt (
            .clk (clk),
            .rst (rst),
            .en  (entry_en),
            .inc (bus.upd_taken),
            .cnt (cnt_arr[gi])
        );
    end

    // Prediction is the MSB of the addressed counter (pre-update value).
    assign bus.pred_taken = cnt_arr[pred_idx][1];

    // Mispredict looks only at the resolved outcome vs. the issued guess.
    assign mispredict_w   = bus.upd_valid & (bus.upd_taken != bus.upd_pred);
    assign bus.mispredict = mispredict_w;

`ifdef BHT_STATS_EN
    logic [31:0] stat_branches_reg;
    logic [31:0] stat_mispredicts_reg;

    // Saturating event counters for resolved branches and mispredicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches_reg    <= 32'd0;
            stat_mispredicts_reg <= 32'd0;
        end else begin
            if (bus.upd_valid && (stat_branches_reg != 32'hFFFF_FFFF)) begin
                stat_branches_reg <= stat_branches_reg + 32'd1;
            end
            if (mispredict_w && (stat_mispredicts_reg != 32'hFFFF_FFFF)) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
            end
        end
    end

    assign bus.stat_branches    = stat_branches_reg;
    assign bus.stat_mispredicts = stat_mispredicts_reg;
`else
    assign bus.stat_branches    = 32'd0;
    assign bus.stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// Directed, table-driven bench for branch_history_table (ENTRIES = 64).
// Statistics expectations follow BHT_STATS_EN the same way the design does.
module tb_branch_history_table;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    branch_history_table_if bus ();

    branch_history_table #(.ENTRIES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic        upd_pred;
        logic [31:0] pred_pc;
        logic        exp_pred;
        logic        exp_mp;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_br  = 32'd0;
    logic [31:0] exp_mis = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [31:0] upc, input logic t,
                                input logic p, input logic [31:0] ppc,
                                input logic ep, input logic emp);
        vec_t r;
        r.upd_valid = v;  r.upd_pc  = upc; r.upd_taken = t; r.upd_pred = p;
        r.pred_pc   = ppc; r.exp_pred = ep; r.exp_mp   = emp;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] upc, input logic t,
                         input logic p, input logic [31:0] ppc);
        bus.upd_valid = v;
        bus.upd_pc    = upc;
        bus.upd_taken = t;
        bus.upd_pred  = p;
        bus.pred_pc   = ppc;
    endtask

    task automatic model_stats(input logic v, input logic mp);
`ifdef BHT_STATS_EN
        if (v)  exp_br  = exp_br + 32'd1;
        if (mp) exp_mis = exp_mis + 32'd1;
`else
        if (v || mp) begin
            exp_br  = 32'd0;
            exp_mis = 32'd0;
        end
`endif
    endtask

    initial begin
        //            valid upd_pc        tk  prd pred_pc       exp_pred exp_mp
        vecs[0]  = mk(1, 32'h0000_0040, 1, 0, 32'h0000_0040, 0, 1); // WNT->WT
        vecs[1]  = mk(1, 32'h0000_0040, 1, 1, 32'h0000_0040, 1, 0); // WT->ST
        vecs[2]  = mk(1, 32'h0000_0040, 1, 1, 32'h0000_0040, 1, 0); // ST holds
        vecs[3]  = mk(1, 32'h0000_0040, 1, 1, 32'h0000_0040, 1, 0); // ST holds
        vecs[4]  = mk(0, 32'h0000_0000, 0, 0, 32'h0000_0140, 1, 0); // alias of 0x40
        vecs[5]  = mk(0, 32'h0000_0000, 0, 0, 32'h0000_0044, 0, 0); // neighbour untouched
        vecs[6]  = mk(1, 32'h0000_0040, 0, 1, 32'h0000_0040, 1, 1); // ST->WT
        vecs[7]  = mk(1, 32'h0000_0040, 0, 1, 32'h0000_0040, 1, 1); // WT->WNT
        vecs[8]  = mk(1, 32'h0000_0040, 0, 0, 32'h0000_0040, 0, 0); // WNT->SNT
        vecs[9]  = mk(1, 32'h0000_0040, 0, 0, 32'h0000_0040, 0, 0); // SNT holds
        vecs[10] = mk(1, 32'h0000_0040, 1, 0, 32'h0000_0040, 0, 1); // SNT->WNT
        vecs[11] = mk(0, 32'h0000_0000, 0, 0, 32'h0000_0040, 0, 0); // still WNT
        vecs[12] = mk(1, 32'h0000_0040, 1, 0, 32'h0000_0040, 0, 1); // WNT->WT
        vecs[13] = mk(0, 32'h0000_0000, 0, 0, 32'h0000_0040, 1, 0); // WT visible
        vecs[14] = mk(1, 32'h0000_0080, 1, 0, 32'h0000_0080, 0, 1); // same-cycle R/W: old value
        vecs[15] = mk(0, 32'h0000_0000, 0, 0, 32'h0000_0080, 1, 0); // new value next cycle
        vecs[16] = mk(0, 32'h0000_0044, 1, 0, 32'h0000_0044, 0, 0); // valid=0: no mp, no write
        vecs[17] = mk(0, 32'h0000_0000, 0, 0, 32'h0000_0044, 0, 0); // still WNT
        vecs[18] = mk(1, 32'h0000_00C3, 1, 1, 32'h0000_00C0, 0, 0); // low PC bits ignored
        vecs[19] = mk(0, 32'h0000_0000, 0, 0, 32'h0123_00C2, 1, 0); // high/low bits ignored

        drive(0, 32'h0, 0, 0, 32'h0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset sweep: every entry predicts not-taken, stats are zero.
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            drive(0, 32'h0, 1, 0, 32'(i * 4));
            #1;
            check($sformatf("reset_pred_%0h", i * 4), {31'd0, bus.pred_taken}, 32'd0);
        end
        check("reset_mispredict", {31'd0, bus.mispredict}, 32'd0);
        check("reset_stat_branches", bus.stat_branches, 32'd0);
        check("reset_stat_mispredicts", bus.stat_mispredicts, 32'd0);
        $display("reset sweep done: 64 PCs checked");

        // Table-driven vectors.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].upd_valid, vecs[i].upd_pc, vecs[i].upd_taken,
                  vecs[i].upd_pred, vecs[i].pred_pc);
            #1;
            $display("vec %0d: valid=%0b upd_pc=%h taken=%0b pred=%0b pred_pc=%h -> pred_taken=%0b mispredict=%0b",
                     i, vecs[i].upd_valid, vecs[i].upd_pc, vecs[i].upd_taken, vecs[i].upd_pred,
                     vecs[i].pred_pc, bus.pred_taken, bus.mispredict);
            check($sformatf("vec%0d_pred_taken", i), {31'd0, bus.pred_taken}, {31'd0, vecs[i].exp_pred});
            check($sformatf("vec%0d_mispredict", i), {31'd0, bus.mispredict}, {31'd0, vecs[i].exp_mp});
            model_stats(vecs[i].upd_valid, vecs[i].exp_mp);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_stat_branches", i), bus.stat_branches, exp_br);
            check($sformatf("vec%0d_stat_mispredicts", i), bus.stat_mispredicts, exp_mis);
        end

        // Reset concurrent with an update: reset wins, update dropped.
        @(negedge clk);
        rst = 1'b1;
        drive(1, 32'h0000_0100, 1, 0, 32'h0000_0100);
        @(posedge clk);
        #1;
        exp_br  = 32'd0;
        exp_mis = 32'd0;
        check("rst_upd_stat_branches", bus.stat_branches, 32'd0);
        check("rst_upd_stat_mispredicts", bus.stat_mispredicts, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 32'h0, 0, 0, 32'h0000_0100);
        #1;
        check("rst_upd_pred_0x100", {31'd0, bus.pred_taken}, 32'd0);
        bus.pred_pc = 32'h0000_0040;
        #1;
        check("rst_clears_0x40", {31'd0, bus.pred_taken}, 32'd0);
        $display("reset+update: stats=%0d/%0d", bus.stat_branches, bus.stat_mispredicts);

        // One taken update must reach WT only if the entry really is WNT.
        @(negedge clk);
        drive(1, 32'h0000_0100, 1, 0, 32'h0000_0100);
        #1;
        check("post_rst_pre_edge_pred", {31'd0, bus.pred_taken}, 32'd0);
        model_stats(1'b1, 1'b1);
        @(negedge clk);
        drive(0, 32'h0, 0, 0, 32'h0000_0100);
        #1;
        check("post_rst_wnt_to_wt", {31'd0, bus.pred_taken}, 32'd1);
        check("post_rst_stat_branches", bus.stat_branches, exp_br);
        check("post_rst_stat_mispredicts", bus.stat_mispredicts, exp_mis);
        $display("post-reset taken update: pred_taken=%0b", bus.pred_taken);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_history_table.md
# branch_history_table

Dynamic branch direction predictor on the fetch side of the rv32i core.
- Fetch side: given the fetch PC, it predicts whether a conditional branch will be taken.
- Execute side: it is trained by the resolved branch outcome from the execute-stage branch comparator.
- Storage: a direct-mapped table of 2-bit saturating counters indexed by PC.
- Mispredict: flagged in the same cycle the resolved outcome arrives.

## Interface
Parameters:
- ENTRIES, 64: number of counters; power of two, 4..1024.
- IDX_W, $clog2(ENTRIES): index width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- pred_pc  input  32  fetch PC to predict for.
- pred_taken  output  1  prediction for pred_pc; combinational.
- upd_valid  input  1  a conditional branch resolved this cycle (Branch asserted in execute).
- upd_pc  input  32  PC of the resolved branch.
- upd_taken  input  1  resolved direction (BrTaken).
- upd_pred  input  1  prediction originally issued for that branch.
- mispredict  output  1  upd_valid & (upd_taken != upd_pred); combinational.
- stat_branches  output  32  resolved-branch count (see Configuration).
- stat_mispredicts  output  32  mispredict count (see Configuration).

## Operation
- Index: pred_pc[IDX_W+1:2] for lookup and upd_pc[IDX_W+1:2] for update. PC bits [1:0] and the bits above the index are ignored, so aliasing is permitted.
- Counter encoding:
  - 00 strongly not-taken (SNT)
  - 01 weakly not-taken (WNT)
  - 10 weakly taken (WT)
  - 11 strongly taken (ST)
- pred_taken = counter[index][1].
- Update:
  - Applies when upd_valid = 1.
  - upd_taken = 1: counter increments, saturating at 11.
  - upd_taken = 0: counter decrements, saturating at 00.
- upd_valid = 0: no counter changes.
- Only the indexed entry is written. All other entries hold.
- mispredict depends only on the current upd_* inputs; table contents do not affect it.
- Reset:
  - All counters go to 01 (WNT), so pred_taken = 0 for every PC after reset.
  - Statistics counters go to 0.
  - mispredict is 0 whenever upd_valid is 0.
- rst asserted concurrently with upd_valid: reset wins and the update is dropped.

## Timing
- Lookup latency 0: pred_taken is combinational from pred_pc and current table state.
- Update latency 1: the new counter value is visible on pred_taken from the cycle after the upd_valid edge.
- Same index read and updated in the same cycle: pred_taken shows the pre-update value. There is no write-to-read bypass.
- Back-to-back updates to one index accumulate, one step per cycle. Example: 00 to 11 takes three consecutive taken updates.
- No handshake. upd_valid is a single-cycle qualifier, and every asserted cycle is consumed.

## Configuration
- Macro BHT_STATS_EN.
- Defined:
  - stat_branches increments by 1 on every cycle with upd_valid = 1.
  - stat_mispredicts increments by 1 on every cycle with mispredict = 1.
  - Both counters saturate at 32'hFFFF_FFFF and never wrap.
  - Both are synchronously cleared by rst.
- Undefined:
  - No statistics registers exist.
  - stat_branches and stat_mispredicts are tied to 32'd0.
  - The ports remain, so the interface is unchanged.

## Structure
- Shared package bht_pkg holds:
  - The 2-bit counter type.
  - Constants BHT_SNT = 2'b00, BHT_WNT = 2'b01, BHT_WT = 2'b10, BHT_ST = 2'b11.
  - The reset value constant BHT_RESET = BHT_WNT.
- Sub-module sat_counter2 holds one 2-bit saturating counter, with inputs clk, rst, en, inc and output cnt.
  - The table is a generate array of ENTRIES instances.
  - Each instance's en is upd_valid qualified by an index match.

## Test plan
1. Reset, then sweep pred_pc over 0x0000_0000..0x0000_00FC -> pred_taken = 0 for all PCs; stat_branches and stat_mispredicts = 0.
2. Three upd_valid cycles with upd_pc = 0x0000_0040, upd_taken = 1 -> pred_taken at pred_pc 0x40 is 0 before the first edge and 1 after the first edge (10), and the counter holds 11 after the third edge. A fourth taken update keeps it at 11.
3. Starting from ST at 0x40, one not-taken update -> WT, pred_taken stays 1; a second not-taken update -> WNT, pred_taken = 0. Two further not-taken updates saturate at 00.
4. Aliasing with ENTRIES = 64: train 0x0000_0040 taken twice -> pred_pc 0x0000_0140 also predicts 1. Neighbour 0x0000_0044 stays 0.
5. Same-cycle read/write: pred_pc = upd_pc = 0x80 with entry at WNT and upd_taken = 1 -> pred_taken = 0 in that cycle and 1 in the next.
6. Mispredict and statistics (BHT_STATS_EN defined): 5 updates, 2 of them with upd_taken != upd_pred -> mispredict pulses exactly twice; stat_branches = 5 and stat_mispredicts = 2. rst together with upd_valid -> both statistics 0 and the counter unchanged from its reset value 01. With the macro undefined, both statistics read 0 throughout.
